// File: rtl/cpu_nic_if.sv
// Processor and router signals of the NIC, bundled as one bus.
interface cpu_nic_if;
    logic [0:1]  addr;
    logic [0:63] d_in;
    logic [0:63] d_out;
    logic        nicEn;
    logic        nicWrEn;
    logic        net_si;
    logic        net_ri;
    logic [0:63] net_di;
    logic        net_so;
    logic        net_ro;
    logic [0:63] net_do;
    logic        net_polarity;

    // Master: processor plus router side, driving the NIC.
    modport master (
        output addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ro, net_polarity,
        input  d_out, net_ri, net_so, net_do
    );

    // Slave: the NIC itself.
    modport slave (
        input  addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ro, net_polarity,
        output d_out, net_ri, net_so, net_do
    );
endinterface

// File: rtl/cpu_nic.sv
// Single-entry NIC: one receive buffer and one send buffer between a
// processor register port and a router link with even/odd phase gating.
module cpu_nic (
    input  logic      clk,
    input  logic      reset,
    cpu_nic_if.slave  nic
);
    localparam int unsigned DATA_W = 64;

    localparam logic [0:1] ADDR_IN_BUF  = 2'b00;
    localparam logic [0:1] ADDR_IN_STS  = 2'b01;
    localparam logic [0:1] ADDR_OUT_BUF = 2'b10;
    localparam logic [0:1] ADDR_OUT_STS = 2'b11;

    logic [0:DATA_W-1] r_in_buf;
    logic              r_in_full;
    logic [0:DATA_W-1] r_out_buf;
    logic              r_out_full;

    logic              w_rd;
    logic              w_wr;
    logic              w_rd_in_buf;
    logic              w_wr_out_buf;
    logic              w_net_accept;
    logic              w_net_so;

    // Decoded processor accesses and link handshakes.
    assign w_rd         = nic.nicEn & ~nic.nicWrEn;
    assign w_wr         = nic.nicEn &  nic.nicWrEn;
    assign w_rd_in_buf  = w_rd & (nic.addr == ADDR_IN_BUF);
    assign w_wr_out_buf = w_wr & (nic.addr == ADDR_OUT_BUF) & ~r_out_full;
    assign w_net_accept = nic.net_si & ~r_in_full;
    // Packets leave only on the router phase that matches their bit 0.
    assign w_net_so     = r_out_full & nic.net_ro & (r_out_buf[0] == nic.net_polarity);

    assign nic.net_ri = ~r_in_full;
    assign nic.net_so = w_net_so;
    assign nic.net_do = r_out_buf;

    // Receive side: capture from router when empty, drain on processor read.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_buf  <= '0;
            r_in_full <= 1'b0;
        end else if (w_net_accept) begin
            r_in_buf  <= nic.net_di;
            r_in_full <= 1'b1;
        end else if (w_rd_in_buf) begin
            r_in_full <= 1'b0;
        end
    end

    // Send side: load from processor when empty, drain when router takes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_buf  <= '0;
            r_out_full <= 1'b0;
        end else if (w_net_so) begin
            r_out_full <= 1'b0;
        end else if (w_wr_out_buf) begin
            r_out_buf  <= nic.d_in;
            r_out_full <= 1'b1;
        end
    end

    // Processor read mux; status flags sit in the last bit (d_out[63]).
    always_comb begin
        nic.d_out = '0;
        if (w_rd) begin
            case (nic.addr)
                ADDR_IN_BUF:  nic.d_out = r_in_buf;
                ADDR_IN_STS:  nic.d_out = {{(DATA_W-1){1'b0}}, r_in_full};
                ADDR_OUT_STS: nic.d_out = {{(DATA_W-1){1'b0}}, r_out_full};
                default:      nic.d_out = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_nic.sv
// Self-checking bench for cpu_nic: read results and router-bound packets
// are predicted into queues and checked as the DUT produces them.
module tb_cpu_nic;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    logic [0:63] rd_q[$];
    logic [0:63] tx_q[$];

    cpu_nic_if bus ();

    cpu_nic dut (
        .clk   (clk),
        .reset (reset),
        .nic   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Router sink: every net_so beat must match the oldest expected packet.
    always @(negedge clk) begin
        logic [0:63] exp_pkt;
        if (!reset && bus.net_so === 1'b1) begin
            total++;
            if (tx_q.size() == 0) begin
                bad++;
                $display("FAIL net_so_spurious: net_so=1 net_do=%h required no send", bus.net_do);
            end else begin
                exp_pkt = tx_q.pop_front();
                if (bus.net_do !== exp_pkt) begin
                    bad++;
                    $display("FAIL net_do: got %h required %h", bus.net_do, exp_pkt);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [0:1] a, input logic [0:63] exp, input string nm);
        logic [0:63] e;
        bus.addr    = a;
        bus.nicEn   = 1'b1;
        bus.nicWrEn = 1'b0;
        rd_q.push_back(exp);
        @(negedge clk);
        e = rd_q.pop_front();
        total++;
        if (bus.d_out !== e) begin
            bad++;
            $display("FAIL %s: d_out=%h required %h", nm, bus.d_out, e);
        end
        step();
        bus.nicEn = 1'b0;
    endtask

    // Processor write; d_out must read zero while writing.
    task automatic do_write(input logic [0:1] a, input logic [0:63] d);
        bus.addr    = a;
        bus.d_in    = d;
        bus.nicEn   = 1'b1;
        bus.nicWrEn = 1'b1;
        @(negedge clk);
        total++;
        if (bus.d_out !== 64'h0) begin
            bad++;
            $display("FAIL d_out_during_write: d_out=%h required 0", bus.d_out);
        end
        step();
        bus.nicEn   = 1'b0;
        bus.nicWrEn = 1'b0;
    endtask

    task automatic check_link(input logic exp_ri, input logic exp_so, input string nm);
        @(negedge clk);
        total++;
        if (bus.net_ri !== exp_ri || bus.net_so !== exp_so) begin
            bad++;
            $display("FAIL %s: net_ri=%b net_so=%b required net_ri=%b net_so=%b",
                     nm, bus.net_ri, bus.net_so, exp_ri, exp_so);
        end
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        check_link(1'b1, 1'b0, "reset_link");
        total++;
        if (bus.net_do !== 64'h0 || bus.d_out !== 64'h0) begin
            bad++;
            $display("FAIL reset_data: net_do=%h d_out=%h required 0 and 0", bus.net_do, bus.d_out);
        end
        do_read(2'b01, 64'h0, "reset_in_status");
        do_read(2'b11, 64'h0, "reset_out_status");
        do_read(2'b00, 64'h0, "reset_in_buf");
        do_read(2'b10, 64'h0, "read_out_buf_addr");
    endtask

    task automatic test_rx();
        bus.net_di = 64'hA5A5_0000_1234_5678;
        bus.net_si = 1'b1;
        check_link(1'b1, 1'b0, "rx_ready_before");
        bus.net_si = 1'b0;
        check_link(1'b0, 1'b0, "rx_full_after");
        do_read(2'b01, 64'h1, "rx_status_full");
        do_read(2'b00, 64'hA5A5_0000_1234_5678, "rx_data");
        check_link(1'b1, 1'b0, "rx_drained");
        do_read(2'b01, 64'h0, "rx_status_empty");
        do_read(2'b00, 64'hA5A5_0000_1234_5678, "rx_data_retained");
    endtask

    task automatic test_rx_drop();
        bus.net_di = 64'h0123_4567_89AB_CDEF;
        bus.net_si = 1'b1;
        step();
        bus.net_di = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        bus.net_si = 1'b0;
        do_read(2'b00, 64'h0123_4567_89AB_CDEF, "rx_second_ignored");
        do_read(2'b01, 64'h0, "rx_drop_status");
    endtask

    task automatic test_tx_polarity();
        bus.net_ro       = 1'b1;
        bus.net_polarity = 1'b0;
        do_write(2'b10, 64'h8000_0000_0000_00C3);
        check_link(1'b1, 1'b0, "tx_wrong_phase");
        do_read(2'b11, 64'h1, "tx_status_full");
        total++;
        if (bus.net_do !== 64'h8000_0000_0000_00C3) begin
            bad++;
            $display("FAIL tx_net_do_held: net_do=%h required %h", bus.net_do, 64'h8000_0000_0000_00C3);
        end
        tx_q.push_back(64'h8000_0000_0000_00C3);
        bus.net_polarity = 1'b1;
        check_link(1'b1, 1'b1, "tx_right_phase");
        check_link(1'b1, 1'b0, "tx_one_cycle");
        do_read(2'b11, 64'h0, "tx_status_empty");
        bus.net_polarity = 1'b0;
    endtask

    task automatic test_tx_drop();
        bus.net_ro = 1'b0;
        do_write(2'b10, 64'h1);
        do_write(2'b10, 64'h2);
        total++;
        if (bus.net_do !== 64'h1) begin
            bad++;
            $display("FAIL tx_second_dropped: net_do=%h required %h", bus.net_do, 64'h1);
        end
        do_write(2'b00, 64'hDEAD_BEEF_0000_0001);
        do_write(2'b11, 64'hDEAD_BEEF_0000_0002);
        do_read(2'b00, 64'h0123_4567_89AB_CDEF, "write_in_buf_ignored");
        do_read(2'b01, 64'h0, "write_status_ignored");
        tx_q.push_back(64'h1);
        bus.net_ro = 1'b1;
        check_link(1'b1, 1'b1, "tx_even_phase_send");
        check_link(1'b1, 1'b0, "tx_even_done");
        total++;
        if (tx_q.size() != 0) begin
            bad++;
            $display("FAIL tx_pending: %0d packets not sent, required 0", tx_q.size());
        end
    endtask

    // Back-to-back write then router send with the next write in the gap.
    task automatic test_back_to_back();
        bus.net_ro       = 1'b1;
        bus.net_polarity = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [0:63] pkt;
            pkt = {$urandom(), $urandom()};
            pkt[0] = 1'b0;
            tx_q.push_back(pkt);
            do_write(2'b10, pkt);
            step();
        end
        total++;
        if (tx_q.size() != 0) begin
            bad++;
            $display("FAIL b2b_pending: %0d packets not sent, required 0", tx_q.size());
        end
    endtask

    task automatic test_reset_priority();
        bus.net_ro = 1'b0;
        bus.net_di = 64'h1111_2222_3333_4444;
        bus.net_si = 1'b1;
        step();
        bus.net_si = 1'b0;
        do_write(2'b10, 64'h8000_0000_0000_0005);
        do_read(2'b01, 64'h1, "prio_in_full");
        do_read(2'b11, 64'h1, "prio_out_full");
        bus.net_si       = 1'b1;
        bus.net_di       = 64'h5555_6666_7777_8888;
        bus.net_ro       = 1'b1;
        bus.net_polarity = 1'b1;
        bus.addr         = 2'b10;
        bus.d_in         = 64'h9999_AAAA_BBBB_CCCC;
        bus.nicEn        = 1'b1;
        bus.nicWrEn      = 1'b1;
        reset            = 1'b1;
        step();
        reset       = 1'b0;
        bus.net_si  = 1'b0;
        bus.nicEn   = 1'b0;
        bus.nicWrEn = 1'b0;
        check_link(1'b1, 1'b0, "prio_link");
        total++;
        if (bus.net_do !== 64'h0) begin
            bad++;
            $display("FAIL prio_net_do: net_do=%h required 0", bus.net_do);
        end
        do_read(2'b01, 64'h0, "prio_in_status");
        do_read(2'b11, 64'h0, "prio_out_status");
        do_read(2'b00, 64'h0, "prio_in_buf");
    endtask

    initial begin
        total            = 0;
        bad              = 0;
        reset            = 1'b1;
        bus.addr         = 2'b00;
        bus.d_in         = '0;
        bus.nicEn        = 1'b0;
        bus.nicWrEn      = 1'b0;
        bus.net_si       = 1'b0;
        bus.net_di       = '0;
        bus.net_ro       = 1'b0;
        bus.net_polarity = 1'b0;
        test_reset();
        test_rx();
        test_rx_drop();
        test_tx_polarity();
        test_tx_drop();
        test_back_to_back();
        test_reset_priority();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
